// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA/game definitions.
// Holds the decoded key codes, the tile codes that affect movement,
// the tile map geometry, and the direction type used by the movement stage.
package vga_pkg;

  // Decoded key codes produced by the keyboard decoder.
  localparam logic [3:0] key_1     = 4'h1;
  localparam logic [3:0] key_up    = 4'h2;
  localparam logic [3:0] key_down  = 4'h3;
  localparam logic [3:0] key_left  = 4'h4;
  localparam logic [3:0] key_right = 4'h5;

  // Tile codes with movement semantics.
  localparam logic [3:0] TILE_WALL = 4'h1;
  localparam logic [3:0] TILE_DOOR = 4'h4;

  // Tile map geometry: 32-px tiles on a 32x24 map.
  localparam int TILE_SHIFT = 5;
  localparam int MAP_W      = 32;
  localparam int MAP_H      = 24;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  // A tile stops the player if it is a wall, or a door that is still locked.
  function automatic logic tile_blocks(input logic [3:0] tile, input logic door_open);
    return (tile == TILE_WALL) || ((tile == TILE_DOOR) && !door_open);
  endfunction

endpackage

// File: rtl/vga_if.sv
// vga_if: VGA timing bundle shared by the game stages.
// Only the vertical sync is carried here; it drives the per-frame tick.
interface vga_if;
  logic vsync;

  modport in  (input  vsync);
  modport out (output vsync);
endinterface

// File: rtl/game_frame_tick.sv
// game_frame_tick: one-cycle pulse on each rising edge of vsync.
// Ports:
//   clk     - pixel clock
//   rst_n   - asynchronous active-low reset
//   vsync_i - vertical sync from the timing generator
//   tick_o  - high for the cycle in which vsync is seen rising
module game_frame_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_i,
  output logic tick_o
);

  logic vsync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
    end
  end

  assign tick_o = vsync_i & ~vsync_q;

endmodule

// File: rtl/game_player_move.sv
// game_player_move: per-frame player movement with tile-map collision.
// On every frame tick the candidate position for the held key is computed,
// clamped to the screen, and its two leading corners are looked up in the
// tile ROM. The move commits unless a corner is a wall or a locked door.
// The tile under the player centre is then fetched into current_pix.
// Ports:
//   clk, rst_n          - pixel clock, asynchronous active-low reset
//   key                 - decoded key code (vga_pkg key_*)
//   in                  - VGA timing; only vsync is used
//   door                - door-open flag from the dialog stage
//   map_addr / map_data - tile ROM port, data valid one cycle after address
//   xpos, ypos          - player top-left position in pixels
//   current_pix         - tile code under the player centre
//   busy                - high while a frame update is running
module game_player_move
  import vga_pkg::*;
#(
  parameter int START_X = 64,
  parameter int START_Y = 64,
  parameter int STEP    = 4,
  parameter int PSIZE   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key,
  vga_if.in           in,
  input  logic        door,
  output logic [9:0]  map_addr,
  input  logic [3:0]  map_data,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic [3:0]  current_pix,
  output logic        busy
);

  typedef enum logic [2:0] {WAIT, CAND, PRB_A, PRB_B, DECIDE, CTR, LATCH} state_e;

  localparam logic signed [11:0] STEP_S = 12'(STEP);
  localparam logic signed [11:0] X_MAX  = 12'(1024 - PSIZE);
  localparam logic signed [11:0] Y_MAX  = 12'(768 - PSIZE);

  state_e      state_q, state_d;
  logic [10:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic [3:0]  cpix_q, cpix_d;
  logic [9:0]  addr_q, addr_d;
  logic [10:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  dir_e        dir_q, dir_d;
  logic [3:0]  tile_a_q, tile_a_d;

  logic              tick;
  logic signed [11:0] px_s, py_s, nx_s, ny_s;
  logic              blocked;

  game_frame_tick u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync_i (in.vsync),
    .tick_o  (tick)
  );

  function automatic dir_e key_to_dir(input logic [3:0] k);
    case (k)
      key_up:    return DIR_UP;
      key_down:  return DIR_DOWN;
      key_left:  return DIR_LEFT;
      key_right: return DIR_RIGHT;
      default:   return DIR_NONE;
    endcase
  endfunction

  function automatic logic [10:0] clamp(input logic signed [11:0] v,
                                        input logic signed [11:0] hi);
    if (v < 0)       return 11'd0;
    else if (v > hi) return hi[10:0];
    else             return v[10:0];
  endfunction

  function automatic logic [9:0] tile_addr(input logic [10:0] x, input logic [10:0] y);
    return {y[9:5], x[9:5]};
  endfunction

  // Leading corner for the direction of travel; probe B is the second corner
  // on the same leading edge. With no move both probes hit the top-left.
  function automatic logic [9:0] corner_addr(input dir_e d, input logic is_b,
                                             input logic [10:0] cx,
                                             input logic [10:0] cy);
    logic [10:0] rx, by;
    logic        use_r, use_b;
    rx = cx + 11'(PSIZE - 1);
    by = cy + 11'(PSIZE - 1);
    case (d)
      DIR_UP:    begin use_r = is_b;  use_b = 1'b0; end
      DIR_DOWN:  begin use_r = is_b;  use_b = 1'b1; end
      DIR_LEFT:  begin use_r = 1'b0;  use_b = is_b; end
      DIR_RIGHT: begin use_r = 1'b1;  use_b = is_b; end
      default:   begin use_r = 1'b0;  use_b = 1'b0; end
    endcase
    return tile_addr(use_r ? rx : cx, use_b ? by : cy);
  endfunction

  assign px_s = {1'b0, xpos_q};
  assign py_s = {1'b0, ypos_q};

  always_comb begin
    state_d  = state_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    cpix_d   = cpix_q;
    addr_d   = addr_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    dir_d    = dir_q;
    tile_a_d = tile_a_q;
    nx_s     = px_s;
    ny_s     = py_s;
    blocked  = 1'b0;
    case (state_q)
      WAIT: begin
        if (tick) state_d = CAND;
      end
      CAND: begin
        dir_d = key_to_dir(key);
        case (dir_d)
          DIR_UP:    ny_s = py_s - STEP_S;
          DIR_DOWN:  ny_s = py_s + STEP_S;
          DIR_LEFT:  nx_s = px_s - STEP_S;
          DIR_RIGHT: nx_s = px_s + STEP_S;
          default:   ;
        endcase
        cand_x_d = clamp(nx_s, X_MAX);
        cand_y_d = clamp(ny_s, Y_MAX);
        // Address is registered, so corner A is presented during PRB_A.
        addr_d   = corner_addr(dir_d, 1'b0, cand_x_d, cand_y_d);
        state_d  = PRB_A;
      end
      PRB_A: begin
        addr_d  = corner_addr(dir_q, 1'b1, cand_x_q, cand_y_q);
        state_d = PRB_B;
      end
      PRB_B: begin
        tile_a_d = map_data;
        state_d  = DECIDE;
      end
      DECIDE: begin
        // map_data holds corner B now; door is sampled here so a door opened
        // this frame is already walkable.
        blocked = tile_blocks(tile_a_q, door) | tile_blocks(map_data, door);
        if (!blocked) begin
          xpos_d = cand_x_q;
          ypos_d = cand_y_q;
        end
        addr_d  = tile_addr(xpos_d + 11'(PSIZE / 2), ypos_d + 11'(PSIZE / 2));
        state_d = CTR;
      end
      CTR: begin
        state_d = LATCH;
      end
      LATCH: begin
        cpix_d  = map_data;
        state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT;
      xpos_q  <= 11'(START_X);
      ypos_q  <= 11'(START_Y);
      cpix_q  <= 4'h0;
      addr_q  <= 10'd0;
    end else begin
      state_q <= state_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      cpix_q  <= cpix_d;
      addr_q  <= addr_d;
    end
  end

  // Scratch registers for one update; always rewritten before being read.
  always_ff @(posedge clk) begin
    cand_x_q <= cand_x_d;
    cand_y_q <= cand_y_d;
    dir_q    <= dir_d;
    tile_a_q <= tile_a_d;
  end

  assign map_addr    = addr_q;
  assign xpos        = xpos_q;
  assign ypos        = ypos_q;
  assign current_pix = cpix_q;
  assign busy        = (state_q != WAIT);

endmodule

// File: tb/tb_game_player_move.sv
module tb_game_player_move;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  key0, key1;
  logic        door;
  logic [9:0]  addr0, addr1;
  logic [3:0]  md0, md1;
  logic [10:0] x0, y0, x1, y1;
  logic [3:0]  pix0, pix1;
  logic        busy0, busy1;

  vga_if vif0 ();
  vga_if vif1 ();

  logic [3:0] rom [1024];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         ox, oy, nx, ny;
    logic [3:0] pix;
    bit         ab;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  game_player_move dut0 (
    .clk(clk), .rst_n(rst_n), .key(key0), .in(vif0), .door(door),
    .map_addr(addr0), .map_data(md0), .xpos(x0), .ypos(y0),
    .current_pix(pix0), .busy(busy0)
  );

  // Second instance placed next to the left and bottom screen edges.
  game_player_move #(.START_X(2), .START_Y(736)) dut1 (
    .clk(clk), .rst_n(rst_n), .key(key1), .in(vif1), .door(door),
    .map_addr(addr1), .map_data(md1), .xpos(x1), .ypos(y1),
    .current_pix(pix1), .busy(busy1)
  );

  // Synchronous tile ROM: data one cycle after address.
  always @(posedge clk) begin
    md0 <= rom[addr0];
    md1 <= rom[addr1];
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: counts busy cycles, checks commit timing and pops the
  // expected result when busy falls.
  int cnt[2] = '{0, 0};
  bit pb[2]  = '{1'b0, 1'b0};
  always @(negedge clk) begin
    logic  b;
    int    xv, yv, pv, av, qs;
    exp_t  e;
    string nm;
    for (int w = 0; w < 2; w++) begin
      b  = (w == 1) ? busy1 : busy0;
      xv = (w == 1) ? int'(x1) : int'(x0);
      yv = (w == 1) ? int'(y1) : int'(y0);
      pv = (w == 1) ? int'(pix1) : int'(pix0);
      av = (w == 1) ? int'(addr1) : int'(addr0);
      qs = (w == 1) ? q1.size() : q0.size();
      nm = (w == 1) ? "edge" : "main";
      e  = '{0, 0, 0, 0, 4'h0, 1'b0};
      if (qs > 0) e = (w == 1) ? q1[0] : q0[0];
      if (b) begin
        cnt[w]++;
        if (qs > 0 && !e.ab) begin
          if (cnt[w] == 4) begin
            chk({nm, "_x_before_commit"}, xv, e.ox);
            chk({nm, "_y_before_commit"}, yv, e.oy);
          end
          if (cnt[w] == 5) begin
            chk({nm, "_x_at_commit"}, xv, e.nx);
            chk({nm, "_y_at_commit"}, yv, e.ny);
          end
        end
      end else if (pb[w]) begin
        if (qs == 0) begin
          total++;
          bad++;
          $display("FAIL %s_unexpected_update: x=%0d y=%0d with no expectation", nm, xv, yv);
        end else begin
          if (w == 1) void'(q1.pop_front());
          else        void'(q0.pop_front());
          chk({nm, "_xpos"}, xv, e.nx);
          chk({nm, "_ypos"}, yv, e.ny);
          chk({nm, "_current_pix"}, pv, int'(e.pix));
          if (e.ab) chk({nm, "_map_addr_after_reset"}, av, 0);
          else      chk({nm, "_busy_cycles"}, cnt[w], 6);
        end
        cnt[w] = 0;
      end
      pb[w] = b;
    end
  end

  task automatic frame(input bit w, input logic [3:0] k,
                       input int ox, input int oy, input int nx, input int ny,
                       input logic [3:0] pix, input bit ab);
    exp_t e;
    e = '{ox, oy, nx, ny, pix, ab};
    if (w) begin q1.push_back(e); key1 = k; end
    else   begin q0.push_back(e); key0 = k; end
    @(posedge clk); #1;
    if (w) vif1.vsync = 1'b1;
    else   vif0.vsync = 1'b1;
    @(posedge clk); #1;
    vif0.vsync = 1'b0;
    vif1.vsync = 1'b0;
    if (ab) begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
    end
    repeat (10) @(posedge clk);
    #1;
    chk(w ? "edge_idle_after_frame" : "main_idle_after_frame",
        w ? int'(busy1) : int'(busy0), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 4'h0;
    rst_n = 1'b0;
    key0 = 4'h0;
    key1 = 4'h0;
    door = 1'b0;
    vif0.vsync = 1'b0;
    vif1.vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_xpos", int'(x0), 64);
    chk("reset_ypos", int'(y0), 64);
    chk("reset_current_pix", int'(pix0), 0);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_map_addr", int'(addr0), 0);
    chk("reset_edge_xpos", int'(x1), 2);
    chk("reset_edge_ypos", int'(y1), 736);

    // Idle key on an open map: no movement.
    frame(0, 4'h0, 64, 64, 64, 64, 4'h0, 0);
    // Right held three frames, then back left to x=64.
    frame(0, key_right, 64, 64, 68, 64, 4'h0, 0);
    frame(0, key_right, 68, 64, 72, 64, 4'h0, 0);
    frame(0, key_right, 72, 64, 76, 64, 4'h0, 0);
    frame(0, key_left,  76, 64, 72, 64, 4'h0, 0);
    frame(0, key_left,  72, 64, 68, 64, 4'h0, 0);
    frame(0, key_left,  68, 64, 64, 64, 4'h0, 0);
    // Wall at tile (3,2): right corner x=99 is in it.
    rom[2*32+3] = TILE_WALL;
    frame(0, key_right, 64, 64, 64, 64, 4'h0, 0);
    // Locked door, then opened door.
    rom[2*32+3] = TILE_DOOR;
    frame(0, key_right, 64, 64, 64, 64, 4'h0, 0);
    door = 1'b1;
    frame(0, key_right, 64, 64, 68, 64, 4'h0, 0);
    // Centre (84,80) is tile (2,2).
    rom[2*32+2] = 4'h3;
    frame(0, 4'h0, 68, 64, 68, 64, 4'h3, 0);

    // Screen edges.
    frame(1, key_left, 2, 736, 0, 736, 4'h0, 0);
    frame(1, key_down, 0, 736, 0, 736, 4'h0, 0);
    frame(1, key_up,   0, 736, 0, 732, 4'h0, 0);

    // Reset pulsed during DECIDE: everything back to reset values.
    frame(0, key_right, 68, 64, 64, 64, 4'h0, 1);
    frame(0, 4'h0, 64, 64, 64, 64, 4'h3, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("main_queue_drained", q0.size(), 0);
    chk("edge_queue_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_player_move.md
# game_player_move

Moves the player sprite one step per frame from the decoded key code and resolves collisions against the tile map ROM. Drives the player position and the tile code under the player's centre, `current_pix`. The dialog/overlay stage downstream consumes `current_pix` and returns the `door` flag, which unlocks door tiles here. Sits between the keyboard decoder and the game content/draw stages, in the `clk` domain.

## Interface
- `START_X`, default 64: player x after reset, in pixels.
- `START_Y`, default 64: player y after reset, in pixels.
- `STEP`, default 4: pixels moved per frame.
- `PSIZE`, default 32: player sprite edge length, in pixels.
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `key`  in  4  decoded key code; the `vga_pkg` key codes `key_up`, `key_down`, `key_left`, `key_right` request movement.
- `in`  vga_if.in  -  timing interface. Only `vsync` is used.
- `door`  in  1  door-open flag from the dialog stage.
- `map_addr`  out  10  tile ROM address {ty[4:0], tx[4:0]}.
- `map_data`  in  4  tile code; valid 1 cycle after `map_addr`.
- `xpos`  out  11  player top-left x.
- `ypos`  out  11  player top-left y.
- `current_pix`  out  4  tile code under the player centre.
- `busy`  out  1  high while an update is in progress.

## Operation
- Frame tick: rising edge of `in.vsync`. Detected with a registered previous value.
- FSM states: WAIT, CAND, PRB_A, PRB_B, DECIDE, CTR, LATCH.
- WAIT: when a tick occurs, go to CAND.
- CAND: compute the candidate position in 12-bit signed arithmetic.
  - Up: y − STEP.
  - Down: y + STEP.
  - Left: x − STEP.
  - Right: x + STEP.
  - Any other code: candidate = current position.
  - Clamp the candidate to 0 … 1024−PSIZE in x and 0 … 768−PSIZE in y.
- PRB_A: drive `map_addr` for leading corner A.
- PRB_B: latch `map_data` as A, then drive `map_addr` for leading corner B.
- Leading corners by direction:
  - Up: top-left and top-right.
  - Down: bottom-left and bottom-right.
  - Left: top-left and bottom-left.
  - Right: top-right and bottom-right.
  - No move: top-left, both probes.
  - Bottom and right edges use the pixel at +PSIZE−1.
- Tile index of a pixel: tx = x[9:5], ty = y[9:5] (32-px tiles, 32×24 map).
- DECIDE: latch B. The move is blocked if A or B is `TILE_WALL` (4'h1), or is `TILE_DOOR` (4'h4) while `door`=0. If not blocked, commit the candidate to `xpos`/`ypos`; if blocked, keep the position unchanged.
- CTR: drive `map_addr` for the centre pixel (x+PSIZE/2, y+PSIZE/2) of the committed position.
- LATCH: register `map_data` into `current_pix`, then go to WAIT.
- `busy` is 1 in every state except WAIT.
- A tick while `busy` is ignored; it is not queued.
- A door tile is walkable the same frame `door` rises, because `door` is sampled in DECIDE.

## Timing
- Reset values:
  - `xpos`=START_X, `ypos`=START_Y.
  - `current_pix`=0, `map_addr`=0, `busy`=0.
  - FSM in WAIT; previous-vsync register = 0.
- The tick is registered at cycle T; CAND runs at T+1.
- `xpos`/`ypos` update at the clock edge ending DECIDE (T+4).
- `current_pix` updates at T+6. `busy` is low again from T+6.
- Outputs are stable for the rest of the frame. They are registered, with no combinational path from `key` to outputs.
- Reset asserted mid-update: the FSM aborts immediately and all outputs take their reset values; no partial commit.
- `map_addr` holds its last value in WAIT.

## Structure
- Add to `vga_pkg`:
  - key codes `key_up`, `key_down`, `key_left`, `key_right`, next to the existing `key_1`;
  - `TILE_WALL`=4'h1, `TILE_DOOR`=4'h4;
  - `TILE_SHIFT`=5, `MAP_W`=32, `MAP_H`=24.
- FSM state enum is local to the module.
- One sub-module: `game_frame_tick`, the vsync rising-edge detector with async active-low reset. It is reused by other per-frame game stages.

## Test plan
- Reset release, idle keys, map all 4'h0 → `xpos`=64, `ypos`=64, `current_pix`=0; after the first tick, position is unchanged and `current_pix`=0 at T+6.
- `key_right` held 3 frames, open map → `xpos` = 68, 72, 76, each committed at T+4.
- `key_right` with tile (tx=3, ty=2) = 4'h1, player at x=64, y=64 → corner x=64+4+31=99 lands in tx=3, so the move is blocked and `xpos` stays 64.
- Door tile 4'h4 ahead: with `door`=0 the move is blocked; after `door`=1 the next tick commits the move.
- `key_left` at x=2 → clamps to `xpos`=0; `key_down` at y=736 → `ypos` stays 736.
- Centre on tile 4'h3 → `current_pix`=4'h3 at T+6; `rst_n` pulsed at T+3 → no commit, all outputs return to reset values.
